mf8_seq: RTL and testbench
==========================

MF8_SEQ -- requirements
Module: mf8_seq

Interface
REQ-001 The block SHALL expose these ports: Clk in 1, system clock; Reset in 1, synchronous active-high reset; ROM_Addr out 10, program ROM address; ROM_Data in 16, ROM word, valid the cycle after its address; Inst_Addr out 10, address of the word currently on ROM_Data; Skip out 1, squash to the ALU; Z_Skip in 1, skip request from the ALU; Status_D in 7, ALU flag values; Status_Wr in 7, ALU flag write enables; SREG out 8, status register; Wake in 1, exit sleep; Sleeping out 1, core halted.
REQ-002 There SHALL be one clock, Clk; Reset SHALL be synchronous and active-high.
REQ-003 The ROM SHALL be synchronous: ROM_Data in cycle n equals ROM[ROM_Addr in cycle n-1].

Function
REQ-004 The block SHALL implement the states FILL, RUN, FLUSH and SLEEP.
REQ-005 A word SHALL be "live" when state=RUN and Z_Skip=0; otherwise it is squashed.
REQ-006 Skip SHALL be combinational: Skip = (state!=RUN) | Z_Skip.
REQ-007 FILL SHALL be held for exactly one cycle after Reset deasserts, with ROM_Addr=0, and SHALL then go to RUN with ROM_Addr=1 and Inst_Addr=0.
REQ-008 In RUN with no live control-flow word, ROM_Addr and Inst_Addr SHALL each increment by 1 per cycle, modulo 1024.
REQ-009 When a live word matches RJMP (ROM_Data[15:12]=1100), the target SHALL be Inst_Addr+1+sext(ROM_Data[11:0]), truncated to 10 bits.
REQ-010 When a live word matches BRBS (111100) or BRBC (111101), with s=ROM_Data[2:0] and offset k=sext(ROM_Data[9:3]), the branch SHALL be taken if the effective flag(s) is 1 for BRBS or 0 for BRBC; the target SHALL be Inst_Addr+1+k, truncated to 10 bits.
REQ-011 The effective flag(s) SHALL be forwarded: Status_Wr[s] ? Status_D[s] : SREG[s] for s<7; for s=7 it SHALL be SREG[7], which is 0.
REQ-012 On a taken RJMP or branch, the next edge SHALL set ROM_Addr=target, Inst_Addr=Inst_Addr+1 and state=FLUSH.
REQ-013 FLUSH SHALL last exactly one cycle, asserting Skip; the next edge SHALL set Inst_Addr=target, ROM_Addr=target+1 and state=RUN.
REQ-014 A not-taken branch SHALL behave as a sequential word (1 cycle).
REQ-015 When a live word equals 0x9588 (SLEEP), the next edge SHALL enter SLEEP with ROM_Addr and Inst_Addr frozen at Inst_Addr+1 and Sleeping=1.
REQ-016 In SLEEP, Skip SHALL be 1 and ROM_Data SHALL repeat the word at the frozen address.
REQ-017 Wake=1 in SLEEP SHALL cause the next edge to go to RUN with Sleeping=0 and ROM_Addr=frozen+1; the frozen word then executes live.
REQ-018 Wake SHALL be ignored outside SLEEP.
REQ-019 A squashed word (Z_Skip=1, FLUSH, FILL or SLEEP) SHALL never jump, branch or sleep, and SHALL advance or freeze the address per its state only.
REQ-020 Each edge SHALL update SREG[i], for i=0..6, to Status_D[i] where Status_Wr[i]=1, and SHALL hold it otherwise.
REQ-021 SREG[7] SHALL read constant 0.
REQ-022 SREG updates SHALL occur in every state, including FLUSH and SLEEP.
REQ-023 Z_Skip SHALL be honoured only in RUN; in other states Skip is already 1.

Reset
REQ-024 While Reset=1: state=FILL, ROM_Addr=0, Inst_Addr=0, SREG=0x00, Sleeping=0, and Skip=1.
REQ-025 Reset SHALL dominate Wake, Z_Skip and any live control-flow word in the same cycle.
REQ-026 Reset asserted during FLUSH or SLEEP SHALL abort it and restart at FILL with no residual state.

Verification
REQ-027 Reset 3 cycles, ROM linear NOPs -> Skip=1 for one cycle after release; then ROM_Addr=1,2,3..., Inst_Addr=0,1,2...; ROM_Addr wraps 1023->0.
REQ-028 RJMP -2 (0xCFFE) at address 5 -> FLUSH cycle with Skip=1; Inst_Addr goes 5,6(squashed),4; the next ROM_Addr=5.
REQ-029 SUB producing Z with Status_Wr[1]=1 and Status_D[1]=1, immediately followed by BRBS s=1 k=+3 at address 10 -> branch taken via forwarding; Inst_Addr reaches 14 after one FLUSH; SREG[1]=1.
REQ-030 Z_Skip=1 while RJMP is on ROM_Data -> Skip=1, no jump, sequential addresses continue.
REQ-031 SLEEP at address 20 -> Sleeping=1; ROM_Addr and Inst_Addr hold 21 for 5 cycles with Skip=1; Wake pulse -> RUN with word 21 live, ROM_Addr=22.
REQ-032 Reset asserted during FLUSH and during SLEEP -> all outputs equal the REQ-024 values the next cycle, and the fetch sequence of REQ-027 repeats.

Source files
------------

// File: rtl/mf8_seq.sv
// mf8_seq: instruction fetch sequencer with FILL/RUN/FLUSH/SLEEP control,
// RJMP/BRBS/BRBC redirect with forwarded flags, and the status register.
module mf8_seq (
  input  logic        Clk,
  input  logic        Reset,
  output logic [9:0]  ROM_Addr,
  input  logic [15:0] ROM_Data,
  output logic [9:0]  Inst_Addr,
  output logic        Skip,
  input  logic        Z_Skip,
  input  logic [6:0]  Status_D,
  input  logic [6:0]  Status_Wr,
  output logic [7:0]  SREG,
  input  logic        Wake,
  output logic        Sleeping
);
  typedef enum logic [1:0] {FILL, RUN, FLUSH, SLEEP} state_t;
  state_t state_q, state_d;
  logic [9:0] rom_addr_q, rom_addr_d, inst_addr_q, target;
  logic [6:0] sreg_q, sreg_d;
  logic [7:0] fwd;
  logic live, is_rjmp, is_br, taken;
  assign sreg_d  = (Status_Wr & Status_D) | (~Status_Wr & sreg_q);
  // flag 7 is hard-wired zero, so it sits above the forwarded 7 flags
  assign fwd     = {1'b0, sreg_d};
  assign live    = (state_q == RUN) && !Z_Skip;
  assign is_rjmp = ROM_Data[15:12] == 4'hC;
  assign is_br   = ROM_Data[15:11] == 5'b11110;
  assign taken   = is_rjmp | (is_br & (fwd[ROM_Data[2:0]] ^ ROM_Data[10]));
  assign target  = inst_addr_q + 10'd1 + (is_rjmp ? ROM_Data[9:0] : {{3{ROM_Data[9]}}, ROM_Data[9:3]});
  always_comb begin
    state_d    = state_q;
    rom_addr_d = rom_addr_q + 10'd1;
    case (state_q)
      FILL:  state_d = RUN;
      RUN: begin
        if (live && taken) begin
          state_d    = FLUSH;
          rom_addr_d = target;
        end else if (live && ROM_Data == 16'h9588) begin
          state_d    = SLEEP;
          rom_addr_d = rom_addr_q;
        end
      end
      FLUSH: state_d = RUN;
      SLEEP: begin
        state_d    = Wake ? RUN : SLEEP;
        rom_addr_d = Wake ? rom_addr_q + 10'd1 : rom_addr_q;
      end
      default: state_d = FILL;
    endcase
  end
  // the word on ROM_Data always comes from last cycle's fetch address
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q     <= FILL;
      rom_addr_q  <= '0;
      inst_addr_q <= '0;
      sreg_q      <= '0;
    end else begin
      state_q     <= state_d;
      rom_addr_q  <= rom_addr_d;
      inst_addr_q <= rom_addr_q;
      sreg_q      <= sreg_d;
    end
  end
  assign ROM_Addr  = rom_addr_q;
  assign Inst_Addr = inst_addr_q;
  assign Skip      = (state_q != RUN) | Z_Skip;
  assign SREG      = {1'b0, sreg_q};
  assign Sleeping  = state_q == SLEEP;
endmodule

// File: tb/tb_mf8_seq.sv
// tb_mf8_seq: randomized and directed stimulus against a program-level
// model of the sequencer; expectations are queued and checked by a monitor.
module tb_mf8_seq;
  logic        Clk = 0, Reset = 1, Z_Skip = 0, Wake = 0;
  logic [9:0]  ROM_Addr, Inst_Addr;
  logic [15:0] ROM_Data = 0;
  logic [6:0]  Status_D = 0, Status_Wr = 0;
  logic [7:0]  SREG;
  logic        Skip, Sleeping;
  logic [15:0] rom [1024];
  int checks = 0, errors = 0;

  mf8_seq dut (
    .Clk(Clk), .Reset(Reset), .ROM_Addr(ROM_Addr), .ROM_Data(ROM_Data),
    .Inst_Addr(Inst_Addr), .Skip(Skip), .Z_Skip(Z_Skip), .Status_D(Status_D),
    .Status_Wr(Status_Wr), .SREG(SREG), .Wake(Wake), .Sleeping(Sleeping)
  );

  always #5 Clk = ~Clk;
  always @(posedge Clk) ROM_Data <= rom[ROM_Addr];

  typedef struct {
    logic [9:0] ra, ia;
    logic [7:0] sreg;
    logic       slp, skp;
  } exp_t;
  exp_t q[$];

  localparam int M_FILL = 0, M_RUN = 1, M_FLUSH = 2, M_SLEEP = 3;
  int m_mode = M_FILL, m_pc = 0, m_ia = 0;
  logic [6:0] m_sreg = 0;

  task automatic jump(input int off);
    m_pc   = (m_ia + 1 + off) & 1023;
    m_ia   = (m_ia + 1) & 1023;
    m_mode = M_FLUSH;
  endtask

  task automatic model_step(input bit rst, input bit zs, input logic [6:0] sd, input logic [6:0] sw, input bit wk);
    logic [15:0] w;
    bit live, flag, brbs, brbc;
    int s;
    if (rst) begin
      m_mode = M_FILL; m_pc = 0; m_ia = 0; m_sreg = 0;
      return;
    end
    w    = rom[m_ia];
    live = (m_mode == M_RUN) && !zs;
    s    = int'(w[2:0]);
    brbs = w[15:10] == 6'b111100;
    brbc = w[15:10] == 6'b111101;
    flag = (s == 7) ? 1'b0 : (sw[s] ? sd[s] : m_sreg[s]);
    case (m_mode)
      M_FILL: begin m_mode = M_RUN; m_ia = 0; m_pc = 1; end
      M_RUN: begin
        if (live && w[15:12] == 4'hC)
          jump(w[11] ? int'(w[11:0]) - 4096 : int'(w[11:0]));
        else if (live && ((brbs && flag) || (brbc && !flag)))
          jump(w[9] ? int'(w[9:3]) - 128 : int'(w[9:3]));
        else if (live && w == 16'h9588) begin
          m_mode = M_SLEEP; m_ia = (m_ia + 1) & 1023; m_pc = m_ia;
        end else begin
          m_ia = (m_ia + 1) & 1023; m_pc = (m_pc + 1) & 1023;
        end
      end
      M_FLUSH: begin m_mode = M_RUN; m_ia = m_pc; m_pc = (m_pc + 1) & 1023; end
      default: if (wk) begin m_mode = M_RUN; m_pc = (m_pc + 1) & 1023; end
    endcase
    for (int i = 0; i < 7; i++) if (sw[i]) m_sreg[i] = sd[i];
  endtask

  task automatic cyc(input bit rst, input bit zs, input logic [6:0] sd, input logic [6:0] sw, input bit wk);
    exp_t e;
    @(negedge Clk);
    Reset = rst; Z_Skip = zs; Status_D = sd; Status_Wr = sw; Wake = wk;
    model_step(rst, zs, sd, sw, wk);
    e.ra = m_pc[9:0]; e.ia = m_ia[9:0]; e.sreg = {1'b0, m_sreg};
    e.slp = m_mode == M_SLEEP; e.skp = (m_mode != M_RUN) || zs;
    q.push_back(e);
  endtask

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  initial forever begin
    exp_t e;
    @(posedge Clk); #1;
    if (q.size() != 0) begin
      e = q.pop_front();
      chk("ROM_Addr", 16'(ROM_Addr), 16'(e.ra));
      chk("Inst_Addr", 16'(Inst_Addr), 16'(e.ia));
      chk("SREG", 16'(SREG), 16'(e.sreg));
      chk("Sleeping", 16'(Sleeping), 16'(e.slp));
      chk("Skip", 16'(Skip), 16'(e.skp));
    end
  end

  initial begin
    int loops, naps;
    bit zs, wk;
    logic [6:0] sd, sw;
    for (int i = 0; i < 1024; i++) rom[i] = 16'h0000;
    // linear NOPs across the 1023->0 wrap; Wake must be ignored outside SLEEP
    repeat (3) cyc(1, 0, 0, 0, 0);
    repeat (1100) cyc(0, 0, 7'($urandom), 7'($urandom), 1'($urandom));
    // directed program: RJMP loop at 5, forwarded BRBS at 10, SLEEP at 20
    rom[5] = 16'hCFFE; rom[10] = 16'hF019;
    rom[11] = 16'h9588; rom[12] = 16'h9588; rom[13] = 16'h9588; rom[20] = 16'h9588;
    repeat (3) cyc(1, 0, 0, 0, 0);
    loops = 0; naps = 0;
    for (int n = 0; n < 300 && !(m_mode == M_RUN && m_ia >= 24); n++) begin
      zs = 0; wk = 0; sd = 0; sw = 0;
      if (m_mode == M_RUN && m_ia == 5) begin
        loops++;
        zs = loops >= 3;
      end
      if (m_mode == M_RUN && m_ia == 10) begin sd = 7'h02; sw = 7'h02; end
      if (m_mode == M_SLEEP) begin
        naps++;
        wk = naps > 5;
      end
      cyc(0, zs, sd, sw, wk);
    end
    // reset inside FLUSH, then inside SLEEP, each followed by a clean restart
    repeat (2) cyc(1, 0, 0, 0, 0);
    for (int n = 0; n < 50 && m_mode != M_FLUSH; n++) cyc(0, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 0);
    repeat (6) cyc(0, 0, 0, 0, 0);
    rom[5] = 16'h0000;
    repeat (2) cyc(1, 0, 0, 0, 0);
    for (int n = 0; n < 50 && m_mode != M_SLEEP; n++) cyc(0, 0, 0, 0, 0);
    repeat (2) cyc(0, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 1);
    repeat (6) cyc(0, 0, 0, 0, 0);
    // random program and random control inputs
    cyc(1, 0, 0, 0, 0);
    for (int i = 0; i < 1024; i++) begin
      case ($urandom_range(0, 9))
        0, 1:    rom[i] = {4'hC, 12'($urandom_range(0, 63)) - 12'd32};
        2, 3, 4: rom[i] = {5'b11110, 1'($urandom), 10'($urandom)};
        5:       rom[i] = 16'h9588;
        default: rom[i] = 16'($urandom);
      endcase
    end
    repeat (2) cyc(1, 0, 0, 0, 0);
    for (int n = 0; n < 3000; n++)
      cyc(((m_mode == M_FLUSH || m_mode == M_SLEEP) ? $urandom_range(0, 3) == 0 : $urandom_range(0, 199) == 0),
          $urandom_range(0, 7) == 0, 7'($urandom), 7'($urandom), $urandom_range(0, 3) == 0);
    repeat (3) @(posedge Clk);
    #2;
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d pending expected 0", q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
